dm_access_ctrl: RTL and testbench

//  Two-requester controller for the word-wide data memory. Arbitrates round-robin

---
 rtl/dm_access_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dm_access_ctrl                                               |
// | Description : Round-robin two-requester front end for the word-wide data   |
// |               memory; byte/half stores become read-modify-write, sub-word  |
// |               loads are lane-extracted and zero-extended.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dm_access_ctrl #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [3:0]        req_size,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_gnt;
  logic              r_last_grant;
  logic              r_we;
  logic [1:0]        r_size;
  logic [MEM_AW+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merged;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_any;
  logic              w_gnt;
  logic              w_sel_we;
  logic [1:0]        w_sel_size;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_bad;
  logic              w_word_store;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merged;
  logic              w_unused_addr_hi;

  // Both valid: the requester not served last time wins.
  assign w_any       = |req_valid;
  assign w_gnt       = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_sel_we    = w_gnt ? req_we[1]         : req_we[0];
  assign w_sel_size  = w_gnt ? req_size[3:2]     : req_size[1:0];
  assign w_sel_addr  = w_gnt ? req_addr[63:32]   : req_addr[31:0];
  assign w_sel_wdata = w_gnt ? req_wdata[63:32]  : req_wdata[31:0];

  // Upper address bits alias onto the memory; they are deliberately dropped.
  assign w_unused_addr_hi = &{1'b0, w_sel_addr[31:MEM_AW+2]};

  assign w_bad = (w_sel_size == 2'b11) ||
                 ((w_sel_size == c_SZ_HALF) && w_sel_addr[0]) ||
                 ((w_sel_size == c_SZ_WORD) && (w_sel_addr[1:0] != 2'b00));

  assign w_word_store = r_we && (r_size == c_SZ_WORD);

  always_comb begin
    w_load_data = 32'd0;
    w_merged    = mem_rdata;
    case (r_size)
      c_SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0: begin
            w_load_data = {24'd0, mem_rdata[7:0]};
            w_merged[7:0] = r_wdata[7:0];
          end
          2'd1: begin
            w_load_data = {24'd0, mem_rdata[15:8]};
            w_merged[15:8] = r_wdata[7:0];
          end
          2'd2: begin
            w_load_data = {24'd0, mem_rdata[23:16]};
            w_merged[23:16] = r_wdata[7:0];
          end
          default: begin
            w_load_data = {24'd0, mem_rdata[31:24]};
            w_merged[31:24] = r_wdata[7:0];
          end
        endcase
      end
      c_SZ_HALF: begin
        if (r_addr[1]) begin
          w_load_data = {16'd0, mem_rdata[31:16]};
          w_merged[31:16] = r_wdata[15:0];
        end else begin
          w_load_data = {16'd0, mem_rdata[15:0]};
          w_merged[15:0] = r_wdata[15:0];
        end
      end
      default: begin
        w_load_data = mem_rdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = w_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (r_we && (r_size != c_SZ_WORD)) begin
          w_state_nxt = RMW_WR;
        end else begin
          w_state_nxt = RESP;
        end
      end
      RMW_WR:  w_state_nxt = RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_merged     <= 32'd0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_any) begin
        r_gnt        <= w_gnt;
        r_last_grant <= w_gnt;
        r_we         <= w_sel_we;
        r_size       <= w_sel_size;
        r_addr       <= w_sel_addr[MEM_AW+1:0];
        r_wdata      <= w_sel_wdata;
        r_err        <= w_bad;
        r_rdata      <= 32'd0;
      end
      if (r_state == ACCESS) begin
        if (!r_we) begin
          r_rdata <= w_load_data;
        end else if (r_size != c_SZ_WORD) begin
          r_merged <= w_merged;
        end
      end
    end
  end

  // Outputs are gated by reset so an in-flight write or response dies in the reset cycle.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (!reset) begin
      mem_addr = r_addr[MEM_AW+1:2];
      case (r_state)
        IDLE: begin
          if (w_any) begin
            req_ready = w_gnt ? 2'b10 : 2'b01;
          end
        end
        ACCESS: begin
          if (w_word_store) begin
            mem_we    = 1'b1;
            mem_wdata = r_wdata;
          end
        end
        RMW_WR: begin
          mem_we    = 1'b1;
          mem_wdata = r_merged;
        end
        default: begin
          rsp_valid = r_gnt ? 2'b10 : 2'b01;
          rsp_err   = r_err;
          rsp_rdata = r_rdata;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dm_access_ctrl                                            |
// | Description : Directed self-checking bench for dm_access_ctrl with a       |
// |               behavioural word memory.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dm_access_ctrl;

  localparam int c_AW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [3:0]      req_size;
  logic [63:0]     req_addr;
  logic [63:0]     req_wdata;
  logic [1:0]      rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;
  logic            mem_we;
  logic [c_AW-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  logic [31:0] mem [0:(1<<c_AW)-1];
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_rsp0 = 0;
  int n_rsp1 = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.MEM_AW(c_AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      n_wr <= n_wr + 1;
    end
    if (rsp_valid[0]) n_rsp0 <= n_rsp0 + 1;
    if (rsp_valid[1]) n_rsp1 <= n_rsp1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_we[id]            = we;
    req_size[2*id +: 2]   = size;
    req_addr[32*id +: 32] = addr;
    req_wdata[32*id +: 32] = wdata;
    req_valid[id]         = 1'b1;
  endtask

  // Issue one request; lat = negedges after the accept edge until rsp_valid seen.
  task automatic issue(input int id, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic err, output logic [31:0] rdata);
    int t;
    @(negedge clk);
    set_req(id, we, size, addr, wdata);
    #1;
    t = 0;
    while (!req_ready[id] && t < 20) begin
      @(negedge clk); #1; t++;
    end
    lat = -1; err = 1'bx; rdata = 'x;
    if (!req_ready[id]) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req_valid[id] = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      t = 0;
      do begin
        @(negedge clk); t++;
      end while (!rsp_valid[id] && t < 20);
      if (!rsp_valid[id]) chk("rsp_timeout", 32'd0, 32'd1);
      lat = t; err = rsp_err; rdata = rsp_rdata;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, r0, r1;
    logic err;
    logic [31:0] rd;
    logic [1:0] gnt [0:5];
    logic [31:0] lanes [0:3];

    reset = 1'b1; req_valid = 2'b00; req_we = 2'b00; req_size = 4'd0;
    req_addr = 64'd0; req_wdata = 64'd0;
    for (int i = 0; i < (1 << c_AW); i++) mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Test 1: tie, r0 word store then r1 load
    @(negedge clk);
    set_req(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    set_req(1, 1'b0, 2'b10, 32'h10, 32'h0);
    #1 chk("t1_first_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_access_we", {31'd0, mem_we}, 32'd1);
    chk("t1_access_addr", {22'd0, mem_addr}, 32'd4);
    chk("t1_access_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_rsp0_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t1_rsp0_rdata", rsp_rdata, 32'd0);
    @(negedge clk); #1;
    chk("t1_second_grant", {30'd0, req_ready}, 32'd2);
    chk("t1_mem4", mem[4], 32'hDEADBEEF);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t1_load_no_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("t1_rsp1_valid", {30'd0, rsp_valid}, 32'd2);
    chk("t1_rsp1_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_rsp1_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    chk("t1_rsp_pulse", {30'd0, rsp_valid}, 32'd0);

    // Test 2: store byte via RMW, then load half
    mem[0] = 32'h11223344;
    w0 = n_wr;
    issue(0, 1'b1, 2'b00, 32'h2, 32'h000000AA, lat, err, rd);
    chk("t2_sb_lat", lat, 32'd3);
    chk("t2_sb_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("t2_mem0", mem[0], 32'h11AA3344);
    chk("t2_single_write", n_wr - w0, 32'd1);
    issue(0, 1'b0, 2'b01, 32'h2, 32'h0, lat, err, rd);
    chk("t2_lh_lat", lat, 32'd2);
    chk("t2_lh_data", rd, 32'h000011AA);

    // Test 3: both held valid across six transactions
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    r0 = n_rsp0; r1 = n_rsp1;
    set_req(0, 1'b0, 2'b10, 32'h0, 32'h0);
    set_req(1, 1'b0, 2'b10, 32'h10, 32'h0);
    #1;
    for (int k = 0; k < 6; k++) begin
      int t;
      t = 0;
      while (req_ready == 2'b00 && t < 10) begin
        @(negedge clk); #1; t++;
      end
      gnt[k] = req_ready;
      @(posedge clk); #1;
      if (k == 5) req_valid = 2'b00;
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_grant%0d", k), {30'd0, gnt[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
    repeat (4) @(negedge clk);
    chk("t3_rsp0_count", n_rsp0 - r0, 32'd3);
    chk("t3_rsp1_count", n_rsp1 - r1, 32'd3);

    // Test 4: errors never touch memory
    w0 = n_wr;
    issue(0, 1'b1, 2'b01, 32'h3, 32'h1234, lat, err, rd);
    chk("t4_sh_mis_err", {31'd0, err}, 32'd1);
    chk("t4_sh_mis_rdata", rd, 32'd0);
    issue(1, 1'b0, 2'b11, 32'h20, 32'h0, lat, err, rd);
    chk("t4_size11_err", {31'd0, err}, 32'd1);
    issue(0, 1'b0, 2'b10, 32'h6, 32'h0, lat, err, rd);
    chk("t4_lw_mis_err", {31'd0, err}, 32'd1);
    chk("t4_lw_mis_rdata", rd, 32'd0);
    @(negedge clk);
    chk("t4_no_writes", n_wr - w0, 32'd0);

    // Test 5: reset during RMW_WR of sb 0x4
    mem[1] = 32'hCAFEF00D;
    w0 = n_wr; r0 = n_rsp0;
    @(negedge clk);
    set_req(0, 1'b1, 2'b00, 32'h4, 32'h55);
    #1 chk("t5_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_access_no_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("t5_rmw_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1 chk("t5_we_gated", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("t5_rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("t5_rst_mem_wdata", mem_wdata, 32'd0);
    chk("t5_rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_mem1", mem[1], 32'hCAFEF00D);
    chk("t5_no_write", n_wr - w0, 32'd0);
    chk("t5_no_rsp", n_rsp0 - r0, 32'd0);
    set_req(0, 1'b0, 2'b10, 32'h0, 32'h0);
    set_req(1, 1'b0, 2'b10, 32'h0, 32'h0);
    #1 chk("t5_tie_r0", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Test 6: byte lanes zero-extended, plus high-address aliasing
    mem[8] = 32'h80FF7F01;
    lanes[0] = 32'h01; lanes[1] = 32'h7F; lanes[2] = 32'hFF; lanes[3] = 32'h80;
    for (int b = 0; b < 4; b++) begin
      issue(1, 1'b0, 2'b00, 32'h20 + b, 32'h0, lat, err, rd);
      chk($sformatf("t6_lb%0d", b), rd, lanes[b]);
    end
    issue(0, 1'b0, 2'b10, 32'h1010, 32'h0, lat, err, rd);
    chk("t6_alias_lw", rd, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
